// File: rtl/intcode_mem_pkg.sv
// Shared types for the two-read, one-write Intcode word memory.
// Holds FSM states, the read request bundle and the clear-counter sizing.
package intcode_mem_pkg;

   typedef enum logic {
      MEM_CLEAR,
      MEM_RUN
   } mem_state_e;

   localparam int MEM_ADDR_MAX = 32;

   typedef struct packed {
      logic                    valid;
      logic [MEM_ADDR_MAX-1:0] addr;
   } rd_req_t;

   // One extra bit so the counter can reach Depth without wrapping
   function automatic int clr_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/intcode_mem_if.sv
// Request/response bus of the Intcode memory: two read ports, one write port.
// The requester (fetch/execute side) is the master.
interface intcode_mem_if #(
   parameter int AddrWidth = 8,
   parameter int WordSize  = 64
);
   logic                 rd0_valid;
   logic                 rd0_ready;
   logic [AddrWidth-1:0] rd0_addr;
   logic [WordSize-1:0]  rd0_data;
   logic                 rd0_data_valid;
   logic                 rd0_err;

   logic                 rd1_valid;
   logic                 rd1_ready;
   logic [AddrWidth-1:0] rd1_addr;
   logic [WordSize-1:0]  rd1_data;
   logic                 rd1_data_valid;
   logic                 rd1_err;

   logic                 wr_valid;
   logic                 wr_ready;
   logic [AddrWidth-1:0] wr_addr;
   logic [WordSize-1:0]  wr_data;
   logic                 wr_err;

   modport master (
      output rd0_valid, rd0_addr,
      input  rd0_ready, rd0_data, rd0_data_valid, rd0_err,
      output rd1_valid, rd1_addr,
      input  rd1_ready, rd1_data, rd1_data_valid, rd1_err,
      output wr_valid, wr_addr, wr_data,
      input  wr_ready, wr_err
   );

   modport slave (
      input  rd0_valid, rd0_addr,
      output rd0_ready, rd0_data, rd0_data_valid, rd0_err,
      input  rd1_valid, rd1_addr,
      output rd1_ready, rd1_data, rd1_data_valid, rd1_err,
      input  wr_valid, wr_addr, wr_data,
      output wr_ready, wr_err
   );

endinterface

// File: rtl/intcode_mem_rd_port.sv
// One registered read port: range check, write forwarding, output register.
// req.valid must already be qualified with ready.
module intcode_mem_rd_port
   import intcode_mem_pkg::*;
#(
   parameter int AddrWidth     = 8,
   parameter int WordSize      = 64,
   parameter int Depth         = 256,
   parameter int ForwardWrites = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  rd_req_t              req,
   input  logic [WordSize-1:0]  mem_word,
   input  logic                 wr_acc,
   input  logic [AddrWidth-1:0] wr_addr,
   input  logic [WordSize-1:0]  wr_data,
   output logic [WordSize-1:0]  data,
   output logic                 data_valid,
   output logic                 err
);

   localparam bit Full = (Depth == 2 ** AddrWidth);
   localparam logic [MEM_ADDR_MAX-1:0] DepthW = MEM_ADDR_MAX'(Depth);

   logic                in_range;
   logic                fwd_hit;
   logic [WordSize-1:0] nxt;

   assign in_range = Full | (req.addr < DepthW);
   assign fwd_hit  = (ForwardWrites != 0) && wr_acc
                     && (MEM_ADDR_MAX'(wr_addr) == req.addr);

   always_comb begin
      nxt = mem_word;
      if (!in_range)
         nxt = '0;
      else if (fwd_hit)
         nxt = wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data       <= '0;
         data_valid <= 1'b0;
         err        <= 1'b0;
      end else begin
         data_valid <= req.valid;
         err        <= req.valid & ~in_range;
         if (req.valid)
            data <= nxt;
      end
   end

endmodule

// File: rtl/intcode_mem_2r1w.sv
// Intcode word memory, two read ports and one write port.
// Zeroes every word after reset before accepting any request.
module intcode_mem_2r1w
   import intcode_mem_pkg::*;
#(
   parameter int AddrWidth     = 8,
   parameter int WordSize      = 64,
   parameter int Depth         = 256,
   parameter int ForwardWrites = 1
) (
   input  logic clk,
   input  logic rst_n,
   output logic init_busy,
   intcode_mem_if.slave bus
);

   localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = clr_cnt_w(Depth);
   localparam logic [AddrWidth:0] DepthW = (AddrWidth + 1)'(Depth);
   localparam logic [CntW-1:0] LastW = CntW'(Depth - 1);

   if (Depth < 1 || Depth > 2 ** AddrWidth) begin : g_bad_depth
      $error("intcode_mem_2r1w: Depth out of range");
   end

   mem_state_e          state;
   logic [CntW-1:0]     clr_cnt;
   logic                run;
   logic                wr_acc;
   logic                wr_in_range;
   logic                wr_err_q;
   logic [WordSize-1:0] mem [Depth];
   logic [WordSize-1:0] rd0_word;
   logic [WordSize-1:0] rd1_word;
   rd_req_t             rd0_req;
   rd_req_t             rd1_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= MEM_CLEAR;
         clr_cnt <= '0;
      end else begin
         unique case (state)
            MEM_CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == LastW)
                  state <= MEM_RUN;
            end
            MEM_RUN: state <= MEM_RUN;
            default: state <= MEM_CLEAR;
         endcase
      end
   end

   // Gated by rst_n so busy also drops while reset is held
   assign init_busy = rst_n & (state == MEM_CLEAR);
   assign run       = (state == MEM_RUN);

   assign bus.rd0_ready = run;
   assign bus.rd1_ready = run;
   assign bus.wr_ready  = run;

   assign wr_acc      = bus.wr_valid & run;
   assign wr_in_range = {1'b0, bus.wr_addr} < DepthW;

   always_ff @(posedge clk) begin
      if (state == MEM_CLEAR)
         mem[clr_cnt[IdxW-1:0]] <= '0;
      else if (wr_acc && wr_in_range)
         mem[bus.wr_addr[IdxW-1:0]] <= bus.wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wr_err_q <= 1'b0;
      else
         wr_err_q <= wr_acc & ~wr_in_range;
   end

   assign bus.wr_err = wr_err_q;

   assign rd0_word = mem[bus.rd0_addr[IdxW-1:0]];
   assign rd1_word = mem[bus.rd1_addr[IdxW-1:0]];

   assign rd0_req = '{valid: bus.rd0_valid & run,
                      addr:  MEM_ADDR_MAX'(bus.rd0_addr)};
   assign rd1_req = '{valid: bus.rd1_valid & run,
                      addr:  MEM_ADDR_MAX'(bus.rd1_addr)};

   intcode_mem_rd_port #(
      .AddrWidth     (AddrWidth),
      .WordSize      (WordSize),
      .Depth         (Depth),
      .ForwardWrites (ForwardWrites)
   ) u_rd0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (rd0_req),
      .mem_word   (rd0_word),
      .wr_acc     (wr_acc),
      .wr_addr    (bus.wr_addr),
      .wr_data    (bus.wr_data),
      .data       (bus.rd0_data),
      .data_valid (bus.rd0_data_valid),
      .err        (bus.rd0_err)
   );

   intcode_mem_rd_port #(
      .AddrWidth     (AddrWidth),
      .WordSize      (WordSize),
      .Depth         (Depth),
      .ForwardWrites (ForwardWrites)
   ) u_rd1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (rd1_req),
      .mem_word   (rd1_word),
      .wr_acc     (wr_acc),
      .wr_addr    (bus.wr_addr),
      .wr_data    (bus.wr_data),
      .data       (bus.rd1_data),
      .data_valid (bus.rd1_data_valid),
      .err        (bus.rd1_err)
   );

endmodule

// File: tb/tb_intcode_mem_2r1w.sv
// Scoreboard bench: a full-depth forwarding memory and a 200-word
// non-forwarding memory driven with the same request stream.
module tb_intcode_mem_2r1w;

   typedef struct {
      logic [63:0] data;
      logic        err;
   } exp_t;

   logic clk;
   logic rst_n;
   logic busy_a;
   logic busy_b;

   int n_chk;
   int n_fail;

   exp_t        q [4][$];
   logic        werr_exp [2];
   logic [63:0] ref_a [256];
   logic [63:0] ref_b [256];

   intcode_mem_if #(.AddrWidth(8), .WordSize(64)) bus_a ();
   intcode_mem_if #(.AddrWidth(8), .WordSize(64)) bus_b ();

   intcode_mem_2r1w #(
      .AddrWidth     (8),
      .WordSize      (64),
      .Depth         (256),
      .ForwardWrites (1)
   ) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_busy (busy_a),
      .bus       (bus_a)
   );

   intcode_mem_2r1w #(
      .AddrWidth     (8),
      .WordSize      (64),
      .Depth         (200),
      .ForwardWrites (0)
   ) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_busy (busy_b),
      .bus       (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] outs_a();
      return {busy_a, bus_a.rd0_ready, bus_a.rd1_ready,
              bus_a.wr_ready, bus_a.rd0_data_valid,
              bus_a.rd1_data_valid, bus_a.rd0_err,
              bus_a.rd1_err, bus_a.wr_err};
   endfunction

   function automatic logic [8:0] outs_b();
      return {busy_b, bus_b.rd0_ready, bus_b.rd1_ready,
              bus_b.wr_ready, bus_b.rd0_data_valid,
              bus_b.rd1_data_valid, bus_b.rd0_err,
              bus_b.rd1_err, bus_b.wr_err};
   endfunction

   function automatic exp_t model_a(input logic [7:0] a,
                                    input logic wv,
                                    input logic [7:0] wa,
                                    input logic [63:0] wd);
      exp_t x;
      x.err  = 1'b0;
      x.data = (wv && wa == a) ? wd : ref_a[a];
      return x;
   endfunction

   function automatic exp_t model_b(input logic [7:0] a);
      exp_t x;
      x.err  = (a >= 8'd200);
      x.data = x.err ? 64'd0 : ref_b[a];
      return x;
   endfunction

   task automatic zero_refs();
      for (int i = 0; i < 256; i++) begin
         ref_a[i] = '0;
         ref_b[i] = '0;
      end
   endtask

   task automatic step(input logic r0v, input logic [7:0] r0a,
                       input logic r1v, input logic [7:0] r1a,
                       input logic wv, input logic [7:0] wa,
                       input logic [63:0] wd);
      @(negedge clk);
      bus_a.rd0_valid = r0v;  bus_b.rd0_valid = r0v;
      bus_a.rd0_addr  = r0a;  bus_b.rd0_addr  = r0a;
      bus_a.rd1_valid = r1v;  bus_b.rd1_valid = r1v;
      bus_a.rd1_addr  = r1a;  bus_b.rd1_addr  = r1a;
      bus_a.wr_valid  = wv;   bus_b.wr_valid  = wv;
      bus_a.wr_addr   = wa;   bus_b.wr_addr   = wa;
      bus_a.wr_data   = wd;   bus_b.wr_data   = wd;
      if (r0v) begin
         q[0].push_back(model_a(r0a, wv, wa, wd));
         q[2].push_back(model_b(r0a));
      end
      if (r1v) begin
         q[1].push_back(model_a(r1a, wv, wa, wd));
         q[3].push_back(model_b(r1a));
      end
      werr_exp[0] = 1'b0;
      werr_exp[1] = wv && (wa >= 8'd200);
      if (wv) begin
         ref_a[wa] = wd;
         if (wa < 8'd200)
            ref_b[wa] = wd;
      end
   endtask

   task automatic idle();
      step(0, 8'd0, 0, 8'd0, 0, 8'd0, 64'd0);
   endtask

   task automatic mon(input int k, input logic dv,
                      input logic [63:0] d, input logic e);
      exp_t x;
      chk($sformatf("dv%0d", k), dv, q[k].size() != 0);
      if (q[k].size() != 0) begin
         x = q[k].pop_front();
         if (dv) begin
            chk($sformatf("data%0d", k), d, x.data);
            chk($sformatf("err%0d", k), e, x.err);
         end
      end
   endtask

   always @(posedge clk) begin
      #1;
      mon(0, bus_a.rd0_data_valid, bus_a.rd0_data, bus_a.rd0_err);
      mon(1, bus_a.rd1_data_valid, bus_a.rd1_data, bus_a.rd1_err);
      mon(2, bus_b.rd0_data_valid, bus_b.rd0_data, bus_b.rd0_err);
      mon(3, bus_b.rd1_data_valid, bus_b.rd1_data, bus_b.rd1_err);
      chk("wr_err_a", bus_a.wr_err, werr_exp[0]);
      chk("wr_err_b", bus_b.wr_err, werr_exp[1]);
      werr_exp[0] = 1'b0;
      werr_exp[1] = 1'b0;
   end

   // Called at the instant rst_n is released
   task automatic wait_clear(input string tag);
      int na = 0;
      int nb = 0;
      int cyc = 0;
      #1;
      while ((busy_a || busy_b) && cyc < 1000) begin
         if (busy_a) na++;
         if (busy_b) nb++;
         if (cyc == 0)
            chk({tag, "_ready_clr"},
                {bus_a.rd0_ready, bus_a.rd1_ready, bus_a.wr_ready,
                 bus_b.rd0_ready, bus_b.rd1_ready, bus_b.wr_ready},
                6'h00);
         cyc++;
         @(negedge clk);
      end
      chk({tag, "_clr_len_a"}, na, 256);
      chk({tag, "_clr_len_b"}, nb, 200);
      chk({tag, "_ready_run"},
          {bus_a.rd0_ready, bus_a.rd1_ready, bus_a.wr_ready,
           bus_b.rd0_ready, bus_b.rd1_ready, bus_b.wr_ready},
          6'h3f);
      zero_refs();
   endtask

   function automatic logic [7:0] rnd_addr();
      if ($urandom_range(0, 3) == 0)
         return 8'($urandom_range(190, 219));
      return 8'($urandom_range(0, 15));
   endfunction

   initial begin
      n_chk = 0;
      n_fail = 0;
      werr_exp[0] = 1'b0;
      werr_exp[1] = 1'b0;
      zero_refs();
      rst_n = 1'b0;
      bus_a.rd0_valid = 0; bus_a.rd1_valid = 0; bus_a.wr_valid = 0;
      bus_b.rd0_valid = 0; bus_b.rd1_valid = 0; bus_b.wr_valid = 0;
      bus_a.rd0_addr = 0; bus_a.rd1_addr = 0; bus_a.wr_addr = 0;
      bus_b.rd0_addr = 0; bus_b.rd1_addr = 0; bus_b.wr_addr = 0;
      bus_a.wr_data = 0; bus_b.wr_data = 0;
      #1;
      chk("rst_outs_a", outs_a(), 9'd0);
      chk("rst_outs_b", outs_b(), 9'd0);
      chk("rst_data_a", bus_a.rd0_data, 64'd0);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_clear("boot");

      // cleared image, incl. top word and B's out-of-range read
      step(1, 8'd0, 1, 8'd128, 0, 8'd0, 64'd0);
      step(1, 8'd255, 0, 8'd0, 0, 8'd0, 64'd0);
      idle();

      // write then read next cycle, idle gaps
      step(0, 8'd0, 0, 8'd0, 1, 8'd5, 64'h2A);
      step(1, 8'd5, 0, 8'd0, 0, 8'd0, 64'd0);
      idle();
      idle();

      // same-edge read/write: A forwards, B returns old word
      step(0, 8'd0, 0, 8'd0, 1, 8'd7, 64'h11);
      idle();
      step(0, 8'd0, 1, 8'd7, 1, 8'd7, 64'h99);
      step(1, 8'd7, 1, 8'd7, 0, 8'd0, 64'd0);

      // out-of-range read and write on B
      step(1, 8'd210, 0, 8'd0, 0, 8'd0, 64'd0);
      step(0, 8'd0, 0, 8'd0, 1, 8'd250, 64'h5);
      idle();
      step(1, 8'd250, 1, 8'd199, 0, 8'd0, 64'd0);
      idle();

      // both ports on one word while writes hit its neighbour
      step(0, 8'd0, 0, 8'd0, 1, 8'd3, 64'hDEAD);
      for (int i = 0; i < 6; i++)
         step(1, 8'd3, 1, 8'd3, 1, 8'd4, 64'h100 + 64'(i));
      step(1, 8'd4, 1, 8'd4, 0, 8'd0, 64'd0);
      idle();

      for (int i = 0; i < 60; i++)
         step(1'($urandom_range(0, 1)), rnd_addr(),
              1'($urandom_range(0, 1)), rnd_addr(),
              1'($urandom_range(0, 1)), rnd_addr(),
              {$urandom, $urandom});

      step(0, 8'd0, 0, 8'd0, 1, 8'd5, 64'h2A);
      step(1, 8'd5, 1, 8'd5, 0, 8'd0, 64'd0);
      idle();

      // reset from RUN drops everything, including held data
      #2 rst_n = 1'b0;
      #1;
      chk("run_rst_outs_a", outs_a(), 9'd0);
      chk("run_rst_outs_b", outs_b(), 9'd0);
      chk("run_rst_data_a", bus_a.rd0_data, 64'd0);
      chk("run_rst_data_b", bus_b.rd1_data, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      repeat (100) @(negedge clk);

      // reset 100 cycles into the clear
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_outs_a", outs_a(), 9'd0);
      chk("mid_rst_outs_b", outs_b(), 9'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_clear("reclr");

      step(1, 8'd5, 1, 8'd4, 0, 8'd0, 64'd0);
      step(1, 8'd3, 1, 8'd255, 0, 8'd0, 64'd0);
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
